// File: rtl/mii_rx_frame_decoder.sv
// MII receive frame decoder: strips preamble/SFD, assembles nibbles low-first into bytes,
// checks CRC-32 / length / alignment / rx_er and reports one status strobe per frame.
module mii_rx_frame_decoder #(
    parameter int MIN_LEN = 64,
    parameter int MAX_LEN = 1518
) (
    input  logic        i_clk,
    input  logic        i_nreset,
    input  logic        enet_rx_dv,
    input  logic        enet_rx_er,
    input  logic [3:0]  enet_rx_data,
    output logic        o_valid,
    output logic [7:0]  o_data,
    output logic        o_sof,
    output logic        o_eof,
    output logic        o_frame_ok,
    output logic        o_err_crc,
    output logic        o_err_len,
    output logic        o_err_align,
    output logic        o_err_rx,
    output logic [10:0] o_len,
    output logic [15:0] o_good_count,
    output logic [15:0] o_bad_count
);

    typedef enum logic [1:0] {IDLE, PREAMBLE, DATA, DROP} state_t;

    localparam logic [31:0] CRC_POLY    = 32'hEDB88320;
    localparam logic [31:0] CRC_RESIDUE = 32'hDEBB20E3;
    localparam logic [10:0] MIN_L       = 11'(MIN_LEN);
    localparam logic [10:0] MAX_L       = 11'(MAX_LEN);
    localparam logic [10:0] LEN_SAT     = 11'h7FF;

    state_t      state_q, state_d;
    logic        phase_q, phase_d;
    logic [3:0]  low_nib_q, low_nib_d;
    logic [31:0] crc_q, crc_d;
    logic [10:0] cnt_q, cnt_d;
    logic        rx_flag_q, rx_flag_d;
    logic        valid_q, valid_d;
    logic [7:0]  data_q, data_d;
    logic        sof_q, sof_d;
    logic        eof_q, eof_d;
    logic        ok_q, ok_d;
    logic        err_crc_q, err_crc_d;
    logic        err_len_q, err_len_d;
    logic        err_align_q, err_align_d;
    logic        err_rx_q, err_rx_d;
    logic [10:0] len_q, len_d;
    logic [15:0] good_q, good_d;
    logic [15:0] bad_q, bad_d;

    logic [7:0]  rx_byte;
    logic [31:0] crc_next;
    logic        end_crc, end_len;

    // Reflected CRC-32, one byte per call, LSB first.
    function automatic logic [31:0] crc_byte(input logic [31:0] crc, input logic [7:0] b);
        logic [31:0] c;
        c = crc ^ {24'd0, b};
        for (int k = 0; k < 8; k++) begin
            c = c[0] ? ((c >> 1) ^ CRC_POLY) : (c >> 1);
        end
        return c;
    endfunction

    assign rx_byte  = {enet_rx_data, low_nib_q};
    assign crc_next = crc_byte(crc_q, rx_byte);
    assign end_crc  = (crc_q != CRC_RESIDUE);
    assign end_len  = (cnt_q < MIN_L) || (cnt_q > MAX_L);

    always_comb begin
        state_d     = state_q;
        phase_d     = phase_q;
        low_nib_d   = low_nib_q;
        crc_d       = crc_q;
        cnt_d       = cnt_q;
        rx_flag_d   = rx_flag_q;
        valid_d     = 1'b0;
        data_d      = data_q;
        sof_d       = 1'b0;
        eof_d       = 1'b0;
        ok_d        = ok_q;
        err_crc_d   = err_crc_q;
        err_len_d   = err_len_q;
        err_align_d = err_align_q;
        err_rx_d    = err_rx_q;
        len_d       = len_q;
        good_d      = good_q;
        bad_d       = bad_q;

        case (state_q)
            IDLE: begin
                if (enet_rx_dv) begin
                    state_d = (enet_rx_data == 4'h5) ? PREAMBLE : DROP;
                end
            end
            PREAMBLE: begin
                if (!enet_rx_dv) begin
                    state_d = IDLE;
                end else if (enet_rx_data == 4'hD) begin
                    state_d   = DATA;
                    phase_d   = 1'b0;
                    cnt_d     = 11'd0;
                    crc_d     = 32'hFFFFFFFF;
                    rx_flag_d = 1'b0;
                end else if (enet_rx_data != 4'h5) begin
                    state_d = DROP;
                end
            end
            DATA: begin
                if (enet_rx_dv) begin
                    if (enet_rx_er) begin
                        rx_flag_d = 1'b1;
                    end
                    if (!phase_q) begin
                        low_nib_d = enet_rx_data;
                        phase_d   = 1'b1;
                    end else begin
                        phase_d = 1'b0;
                        crc_d   = crc_next;
                        if (cnt_q != LEN_SAT) begin
                            cnt_d = cnt_q + 11'd1;
                        end
                        // Oversized frames keep counting and CRC-checking but stop emitting.
                        if (cnt_q < MAX_L) begin
                            valid_d = 1'b1;
                            data_d  = rx_byte;
                            sof_d   = (cnt_q == 11'd0);
                        end
                    end
                end else begin
                    eof_d       = 1'b1;
                    err_align_d = phase_q;
                    err_crc_d   = end_crc;
                    err_len_d   = end_len;
                    err_rx_d    = rx_flag_q;
                    len_d       = cnt_q;
                    ok_d        = !(phase_q || end_crc || end_len || rx_flag_q);
                    if (!(phase_q || end_crc || end_len || rx_flag_q)) begin
                        good_d = good_q + 16'd1;
                    end else begin
                        bad_d = bad_q + 16'd1;
                    end
                    state_d = IDLE;
                end
            end
            DROP: begin
                if (!enet_rx_dv) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge i_clk or negedge i_nreset) begin
        if (!i_nreset) begin
            state_q     <= IDLE;
            phase_q     <= 1'b0;
            low_nib_q   <= 4'd0;
            crc_q       <= 32'hFFFFFFFF;
            cnt_q       <= 11'd0;
            rx_flag_q   <= 1'b0;
            valid_q     <= 1'b0;
            data_q      <= 8'd0;
            sof_q       <= 1'b0;
            eof_q       <= 1'b0;
            ok_q        <= 1'b0;
            err_crc_q   <= 1'b0;
            err_len_q   <= 1'b0;
            err_align_q <= 1'b0;
            err_rx_q    <= 1'b0;
            len_q       <= 11'd0;
            good_q      <= 16'd0;
            bad_q       <= 16'd0;
        end else begin
            state_q     <= state_d;
            phase_q     <= phase_d;
            low_nib_q   <= low_nib_d;
            crc_q       <= crc_d;
            cnt_q       <= cnt_d;
            rx_flag_q   <= rx_flag_d;
            valid_q     <= valid_d;
            data_q      <= data_d;
            sof_q       <= sof_d;
            eof_q       <= eof_d;
            ok_q        <= ok_d;
            err_crc_q   <= err_crc_d;
            err_len_q   <= err_len_d;
            err_align_q <= err_align_d;
            err_rx_q    <= err_rx_d;
            len_q       <= len_d;
            good_q      <= good_d;
            bad_q       <= bad_d;
        end
    end

    assign o_valid      = valid_q;
    assign o_data       = data_q;
    assign o_sof        = sof_q;
    assign o_eof        = eof_q;
    assign o_frame_ok   = ok_q;
    assign o_err_crc    = err_crc_q;
    assign o_err_len    = err_len_q;
    assign o_err_align  = err_align_q;
    assign o_err_rx     = err_rx_q;
    assign o_len        = len_q;
    assign o_good_count = good_q;
    assign o_bad_count  = bad_q;

endmodule

// File: tb/tb_mii_rx_frame_decoder.sv
// Bench for mii_rx_frame_decoder: frames built from random payloads with a software CRC-32,
// decoded output compared against expectations derived from the frame contents.
module tb_mii_rx_frame_decoder;

    localparam int MIN_LEN = 64;
    localparam int MAX_LEN = 1518;

    typedef logic [7:0] byte_q_t[$];

    logic        i_clk = 1'b0;
    logic        i_nreset = 1'b0;
    logic        enet_rx_dv = 1'b0;
    logic        enet_rx_er = 1'b0;
    logic [3:0]  enet_rx_data = 4'd0;
    logic        o_valid, o_sof, o_eof, o_frame_ok;
    logic        o_err_crc, o_err_len, o_err_align, o_err_rx;
    logic [7:0]  o_data;
    logic [10:0] o_len;
    logic [15:0] o_good_count, o_bad_count;

    mii_rx_frame_decoder #(.MIN_LEN(MIN_LEN), .MAX_LEN(MAX_LEN)) dut (
        .i_clk(i_clk), .i_nreset(i_nreset),
        .enet_rx_dv(enet_rx_dv), .enet_rx_er(enet_rx_er), .enet_rx_data(enet_rx_data),
        .o_valid(o_valid), .o_data(o_data), .o_sof(o_sof), .o_eof(o_eof),
        .o_frame_ok(o_frame_ok), .o_err_crc(o_err_crc), .o_err_len(o_err_len),
        .o_err_align(o_err_align), .o_err_rx(o_err_rx), .o_len(o_len),
        .o_good_count(o_good_count), .o_bad_count(o_bad_count)
    );

    always #5 i_clk = ~i_clk;

    int n_checks = 0;
    int n_errors = 0;
    int exp_good = 0;
    int exp_bad  = 0;

    task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    // Output monitor
    byte_q_t    mon_bytes;
    int         mon_sof_cnt = 0;
    int         mon_sof_pos = -1;
    int         mon_eof_cnt = 0;
    logic       cap_ok, cap_crc, cap_len_e, cap_align, cap_rx;
    logic [10:0] cap_len;

    always @(negedge i_clk) begin
        if (o_valid) begin
            if (o_sof) begin
                mon_sof_cnt++;
                mon_sof_pos = mon_bytes.size();
            end
            mon_bytes.push_back(o_data);
        end
        if (o_eof) begin
            check_val("eof_excl_valid", {31'd0, o_valid}, 32'd0);
            mon_eof_cnt++;
            cap_ok    = o_frame_ok;
            cap_crc   = o_err_crc;
            cap_len_e = o_err_len;
            cap_align = o_err_align;
            cap_rx    = o_err_rx;
            cap_len   = o_len;
        end
    end

    task automatic clear_mon();
        mon_bytes.delete();
        mon_sof_cnt = 0;
        mon_sof_pos = -1;
        mon_eof_cnt = 0;
    endtask

    function automatic logic [31:0] crc32(input byte_q_t b, input int n);
        logic [31:0] c;
        c = 32'hFFFFFFFF;
        for (int i = 0; i < n; i++) begin
            c = c ^ {24'd0, b[i]};
            for (int k = 0; k < 8; k++) c = c[0] ? ((c >> 1) ^ 32'hEDB88320) : (c >> 1);
        end
        return ~c;
    endfunction

    function automatic byte_q_t make_frame(input int plen, input int zero_from);
        byte_q_t q;
        logic [31:0] c;
        for (int i = 0; i < plen; i++) q.push_back(i >= zero_from ? 8'h00 : 8'($urandom_range(0, 255)));
        c = crc32(q, plen);
        for (int k = 0; k < 4; k++) q.push_back(c[8*k +: 8]);
        return q;
    endfunction

    // One nibble per clock; rst_at >= 0 pulses i_nreset low for two clocks from that nibble.
    task automatic drive_nibs(input logic [3:0] nq[$], input logic dvq[$], input logic erq[$], input int rst_at);
        for (int i = 0; i < nq.size(); i++) begin
            @(posedge i_clk); #1;
            enet_rx_dv   = dvq[i];
            enet_rx_data = nq[i];
            enet_rx_er   = erq[i];
            if (i == rst_at) begin
                i_nreset = 1'b0;
                #1;
                check_val("rst_valid", {31'd0, o_valid}, 32'd0);
                check_val("rst_data", {24'd0, o_data}, 32'd0);
                check_val("rst_len", {21'd0, o_len}, 32'd0);
                check_val("rst_good", {16'd0, o_good_count}, 32'd0);
                check_val("rst_flags", {26'd0, o_sof, o_eof, o_frame_ok, o_err_crc, o_err_len, o_err_rx}, 32'd0);
            end
            if (rst_at >= 0 && i == rst_at + 2) begin
                i_nreset = 1'b1;
                clear_mon();
            end
        end
        @(posedge i_clk); #1;
        enet_rx_dv = 1'b0; enet_rx_er = 1'b0; enet_rx_data = 4'd0;
    endtask

    task automatic build_nibs(input byte_q_t fr, input int pre_len, input bit extra, input int er_rel,
                              input bit bad_pre, output logic [3:0] nq[$], output logic dvq[$], output logic erq[$]);
        int base;
        nq.delete(); dvq.delete(); erq.delete();
        if (bad_pre) begin
            nq.push_back(4'h5); nq.push_back(4'h5); nq.push_back(4'h3);
            for (int i = 0; i < 12; i++) nq.push_back(4'($urandom_range(0, 15)));
            for (int i = 0; i < 15; i++) begin dvq.push_back(1'b1); erq.push_back(1'b0); end
            nq.push_back(4'h0); dvq.push_back(1'b0); erq.push_back(1'b0);
        end
        for (int i = 0; i < pre_len; i++) begin nq.push_back(4'h5); dvq.push_back(1'b1); erq.push_back(1'b0); end
        nq.push_back(4'hD); dvq.push_back(1'b1); erq.push_back(1'b0);
        base = nq.size();
        foreach (fr[i]) begin
            nq.push_back(fr[i][3:0]); nq.push_back(fr[i][7:4]);
            dvq.push_back(1'b1); dvq.push_back(1'b1); erq.push_back(1'b0); erq.push_back(1'b0);
        end
        if (extra) begin nq.push_back(4'($urandom_range(0, 15))); dvq.push_back(1'b1); erq.push_back(1'b0); end
        if (er_rel >= 0) erq[base + er_rel] = 1'b1;
    endtask

    task automatic run_frame(input string tag, input byte_q_t fr, input int pre_len, input bit extra,
                             input int er_rel, input bit bad_pre);
        logic [3:0] nq[$];
        logic dvq[$], erq[$];
        int n, emit, mism, lim;
        logic [31:0] fcs;
        bit e_crc, e_len, e_ok;
        build_nibs(fr, pre_len, extra, er_rel, bad_pre, nq, dvq, erq);
        clear_mon();
        drive_nibs(nq, dvq, erq, -1);
        for (int w = 0; w < 10 && mon_eof_cnt == 0; w++) @(negedge i_clk);
        repeat (3) @(negedge i_clk);

        n     = fr.size();
        emit  = (n < MAX_LEN) ? n : MAX_LEN;
        fcs   = {fr[n-1], fr[n-2], fr[n-3], fr[n-4]};
        e_crc = (crc32(fr, n - 4) != fcs);
        e_len = (n < MIN_LEN) || (n > MAX_LEN);
        e_ok  = !(e_crc || e_len || extra || (er_rel >= 0));
        if (e_ok) exp_good++; else exp_bad++;

        mism = 0;
        lim  = (mon_bytes.size() < emit) ? mon_bytes.size() : emit;
        for (int i = 0; i < lim; i++) if (mon_bytes[i] !== fr[i]) mism++;

        check_val({tag, ":nbytes"}, mon_bytes.size(), emit);
        check_val({tag, ":byte_mism"}, mism, 0);
        check_val({tag, ":sof_cnt"}, mon_sof_cnt, 1);
        check_val({tag, ":sof_pos"}, mon_sof_pos, 0);
        check_val({tag, ":eof_cnt"}, mon_eof_cnt, 1);
        check_val({tag, ":ok"}, {31'd0, cap_ok}, {31'd0, e_ok});
        check_val({tag, ":err_crc"}, {31'd0, cap_crc}, {31'd0, e_crc});
        check_val({tag, ":err_len"}, {31'd0, cap_len_e}, {31'd0, e_len});
        check_val({tag, ":err_align"}, {31'd0, cap_align}, {31'd0, extra});
        check_val({tag, ":err_rx"}, {31'd0, cap_rx}, {31'd0, er_rel >= 0});
        check_val({tag, ":len"}, {21'd0, cap_len}, (n > 2047) ? 2047 : n);
        check_val({tag, ":good_cnt"}, {16'd0, o_good_count}, exp_good & 32'hFFFF);
        check_val({tag, ":bad_cnt"}, {16'd0, o_bad_count}, exp_bad & 32'hFFFF);
        $display("frame %s len=%0d bytes=%0d ok=%0d crc=%0d len_e=%0d align=%0d rx=%0d",
                 tag, n, mon_bytes.size(), cap_ok, cap_crc, cap_len_e, cap_align, cap_rx);
    endtask

    initial begin
        byte_q_t fr, fr2;
        logic [3:0] nq[$];
        logic dvq[$], erq[$];
        int kind, plen, idx;

        repeat (3) @(negedge i_clk);
        check_val("reset_valid", {31'd0, o_valid}, 32'd0);
        check_val("reset_data", {24'd0, o_data}, 32'd0);
        check_val("reset_len", {21'd0, o_len}, 32'd0);
        check_val("reset_cnts", {o_good_count, o_bad_count}, 32'd0);
        check_val("reset_flags", {25'd0, o_sof, o_eof, o_frame_ok, o_err_crc, o_err_len, o_err_align, o_err_rx}, 32'd0);
        @(posedge i_clk); #1;
        i_nreset = 1'b1;

        fr = make_frame(60, 1000);
        run_frame("good64", fr, 15, 1'b0, -1, 1'b0);

        fr2 = fr;
        fr2[20] = fr2[20] ^ 8'h01;
        run_frame("crc_flip", fr2, 15, 1'b0, -1, 1'b0);

        run_frame("short24", make_frame(20, 1000), 15, 1'b0, -1, 1'b0);
        run_frame("long1600", make_frame(1596, 1000), 15, 1'b0, -1, 1'b0);
        run_frame("align", make_frame(60, 1000), 15, 1'b1, -1, 1'b0);
        run_frame("rx_er", make_frame(60, 1000), 15, 1'b0, 41, 1'b0);
        run_frame("drop_then_good", make_frame(60, 1000), 15, 1'b0, -1, 1'b1);

        // Reset mid-frame at byte 30; payload zeroed from byte 28 so the resumed stream drops.
        fr = make_frame(60, 28);
        build_nibs(fr, 15, 1'b0, -1, 1'b0, nq, dvq, erq);
        clear_mon();
        drive_nibs(nq, dvq, erq, 16 + 60);
        repeat (8) @(negedge i_clk);
        exp_good = 0;
        exp_bad  = 0;
        check_val("rst_mid:bytes_after", mon_bytes.size(), 0);
        check_val("rst_mid:eof_after", mon_eof_cnt, 0);
        check_val("rst_mid:cnts", {o_good_count, o_bad_count}, 32'd0);
        $display("frame rst_mid bytes_after=%0d eof_after=%0d", mon_bytes.size(), mon_eof_cnt);
        run_frame("after_reset", make_frame(60, 1000), 15, 1'b0, -1, 1'b0);

        for (int r = 0; r < 10; r++) begin
            kind = $urandom_range(0, 4);
            plen = (kind == 4) ? $urandom_range(10, 50) : $urandom_range(40, 110);
            fr = make_frame(plen, 1000);
            if (kind == 1) begin
                idx = $urandom_range(0, fr.size() - 1);
                fr[idx] = fr[idx] ^ (8'd1 << $urandom_range(0, 7));
            end
            run_frame($sformatf("rand%0d_k%0d", r, kind), fr, $urandom_range(1, 15),
                      kind == 2, (kind == 3) ? $urandom_range(0, 2 * fr.size() - 1) : -1, 1'b0);
        end

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule
